// File: rtl/sr_cmd_debounce_if.sv
// Button inputs and S-R command outputs of the debounce front-end.
interface sr_cmd_debounce_if;
    logic btn_set;
    logic btn_reset;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    // Driver side: owns the raw buttons, observes the command outputs.
    modport master (
        output btn_set, btn_reset,
        input  S, R, busy, conflict
    );

    // Design side.
    modport slave (
        input  btn_set, btn_reset,
        output S, R, busy, conflict
    );
endinterface

// File: rtl/sr_cmd_debounce.sv
// Debounced, serialised S/R command generator for a clocked S-R flip-flop.
// Two button channels feed a small FSM that emits one fixed-width pulse per
// press and never drives S and R high together.

// One button channel: 2-flop synchroniser, counter debounce, rising-edge request.
module sr_deb_chan #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic req
);
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        cnt_d     = cnt_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            cnt_q     <= cnt_d;
        end
    end

    // Only a debounced press requests a command; releases are ignored.
    assign req = deb_q & ~deb_dly_q;
endmodule

module sr_cmd_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5,
    parameter int PULSE_LEN  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_cmd_debounce_if.slave     bus
);
    localparam int NUM_CH = 2;  // bit 0 = set, bit 1 = reset

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

    logic [NUM_CH-1:0] btn_raw;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] pend_q, pend_d, pend_now;
    state_t            state_q, state_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic              s_q, s_d, r_q, r_d, busy_q, busy_d, conflict_q, conflict_d;

    assign btn_raw = {bus.btn_reset, bus.btn_set};

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
            sr_deb_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan (
                .clk (clk),
                .rst (rst),
                .btn (btn_raw[ch]),
                .req (req[ch])
            );
        end
    endgenerate

    // A request arriving this cycle is visible to IDLE straight away.
    assign pend_now = pend_q | req;

    // State, pulse counter, pending bits and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            pend_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            pend_q     <= pend_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    // Next state: reset command wins over set; one guard cycle after every pulse.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        pend_d  = pend_now;
        case (state_q)
            IDLE: begin
                if (pend_now[1]) begin
                    state_d = PULSE_R;
                    pcnt_d  = '0;
                    pend_d  = '0;       // a simultaneous set is discarded
                end else if (pend_now[0]) begin
                    state_d   = PULSE_S;
                    pcnt_d    = '0;
                    pend_d[0] = 1'b0;
                end
            end
            PULSE_S, PULSE_R: begin
                if (pcnt_q == 8'(PULSE_LEN - 1)) begin
                    state_d = GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the next state so they register in step with it.
    always_comb begin
        s_d        = (state_d == PULSE_S);
        r_d        = (state_d == PULSE_R);
        busy_d     = (state_d != IDLE);
        conflict_d = (state_q == IDLE) & pend_now[1] & pend_now[0];
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Scoreboard bench: stimulus pushes expected command pulses, a monitor pops
// and compares each pulse when busy falls.
module tb_sr_cmd_debounce;
    localparam int DEB = 16;
    localparam int PL  = 2;
    localparam int LAT = DEB + 3;   // edges from press to first S/R edge

    typedef struct {
        int start;
        int s_cnt;
        int r_cnt;
        int conf_cnt;
        int busy_len;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    ev_t  cur, exp_e;
    bit   in_ev = 1'b0;
    int   c0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_cmd_debounce_if bus();

    sr_cmd_debounce #(.DEB_CYCLES(DEB), .CNT_W(5), .PULSE_LEN(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int start, input bit is_r, input int len,
                               input int conf, input int busy_len);
        ev_t e;
        e.start    = start;
        e.s_cnt    = is_r ? 0 : len;
        e.r_cnt    = is_r ? len : 0;
        e.conf_cnt = conf;
        e.busy_len = busy_len;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle exclusivity, and one scoreboard compare per busy window.
    always @(negedge clk) begin
        check("s_and_r_exclusive", int'(bus.S & bus.R), 0);
        if (in_ev && !bus.busy) begin
            in_ev = 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_start", cur.start, -1);
            end else begin
                exp_e = exp_q.pop_front();
                check("pulse_start",    cur.start,    exp_e.start);
                check("pulse_s_cycles", cur.s_cnt,    exp_e.s_cnt);
                check("pulse_r_cycles", cur.r_cnt,    exp_e.r_cnt);
                check("pulse_conflict", cur.conf_cnt, exp_e.conf_cnt);
                check("pulse_busy_len", cur.busy_len, exp_e.busy_len);
            end
        end
        if (bus.busy) begin
            if (!in_ev) begin
                in_ev = 1'b1;
                cur   = '{cyc, 0, 0, 0, 0};
            end
            cur.s_cnt    += int'(bus.S);
            cur.r_cnt    += int'(bus.R);
            cur.conf_cnt += int'(bus.conflict);
            cur.busy_len += 1;
        end else begin
            check("quiet_while_not_busy", int'(bus.S | bus.R | bus.conflict), 0);
        end
    end

    initial begin
        rst           = 1'b1;
        bus.btn_set   = 1'b1;
        bus.btn_reset = 1'b1;

        // T1: reset held with both buttons high keeps everything low.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_S",        int'(bus.S),        0);
            check("rst_R",        int'(bus.R),        0);
            check("rst_busy",     int'(bus.busy),     0);
            check("rst_conflict", int'(bus.conflict), 0);
        end
        rst           = 1'b0;
        bus.btn_reset = 1'b0;
        c0 = cyc;
        exp_q.push_back(mk(c0 + LAT, 1'b0, PL, 0, PL + 1));
        tick(40);
        bus.btn_set = 1'b0;
        tick(40);

        // T2: clean set, held then released, gives exactly one pulse.
        bus.btn_set = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(c0 + LAT, 1'b0, PL, 0, PL + 1));
        tick(60);
        bus.btn_set = 1'b0;
        tick(40);

        // T3: bounces shorter than the debounce window never pass.
        for (int k = 0; k < 5; k++) begin
            bus.btn_set = 1'b1;
            tick(10);
            bus.btn_set = 1'b0;
            tick(3);
        end
        tick(30);
        bus.btn_set = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(c0 + LAT, 1'b0, PL, 0, PL + 1));
        tick(40);
        bus.btn_set = 1'b0;
        tick(40);

        // T4: simultaneous press -> reset wins, conflict flagged once.
        bus.btn_set   = 1'b1;
        bus.btn_reset = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(c0 + LAT, 1'b1, PL, 1, PL + 1));
        tick(40);
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        tick(40);

        // T5: reset pressed one cycle after set -> queued R after S and guard.
        bus.btn_set = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(c0 + LAT, 1'b0, PL, 0, PL + 1));
        exp_q.push_back(mk(c0 + LAT + PL + 2, 1'b1, PL, 0, PL + 1));
        tick(1);
        bus.btn_reset = 1'b1;
        tick(40);
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        tick(40);

        // T6: reset during first S cycle with R arriving -> S cut, no R later.
        bus.btn_set = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(c0 + LAT, 1'b0, 1, 0, 1));
        tick(1);
        bus.btn_reset = 1'b1;
        tick(LAT - 1);
        check("t6_S_high_before_rst", int'(bus.S), 1);
        rst           = 1'b1;
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        tick(1);
        check("t6_S_after_rst", int'(bus.S), 0);
        check("t6_R_after_rst", int'(bus.R), 0);
        rst = 1'b0;
        tick(60);

        check("pulses_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
